// File: rtl/j2_io_responder.sv
// IO responder for the j2 core: LED register, UART TX FIFO + 8N1 serializer, status, cycle counter.
// Optional cycle counter is built only when J2_IO_COUNTER_EN is defined.
module j2_io_responder #(
   parameter int WIDTH          = 16,
   parameter int FIFO_DEPTH     = 8,
   parameter int CLOCKS_PER_BIT = 434
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [15:0]      io_address,
   input  logic             io_write_enable,
   input  logic             io_read_enable,
   input  logic [WIDTH-1:0] io_write_data,
   output logic [WIDTH-1:0] io_read_data,
   output logic [7:0]       leds,
   output logic             uart_tx
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(CLOCKS_PER_BIT);
   localparam logic [TW-1:0] RELOAD = TW'(CLOCKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

   logic [1:0]    sel;
   logic          wr_led, wr_tx, rd_status;
   logic          full, empty, busy, pop, push_ok;
   logic [3:0]    cnt_sat;
   logic [WIDTH-1:0] cnt_rd;
   logic          unused_bits;

   logic [7:0]    leds_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   tx_state_e     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   assign sel         = io_address[1:0];
   assign wr_led      = io_write_enable && (sel == 2'd0);
   assign wr_tx       = io_write_enable && (sel == 2'd1);
   assign rd_status   = io_read_enable && (sel == 2'd2);
   assign unused_bits = ^{io_address[15:2], io_write_data[WIDTH-1:8]};

   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign busy    = (state_q != S_IDLE);
   assign cnt_sat = (count_q > CW'(15)) ? 4'hF : 4'(count_q);
   // A full FIFO still accepts a push when the serializer pops in the same cycle.
   assign push_ok = wr_tx && (!full || pop);

   assign leds    = leds_q;
   assign uart_tx = tx_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (rd_status)             ovf_d = 1'b0;
      if (wr_tx && full && !pop) ovf_d = 1'b1;
      if (push_ok)               wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)                   rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= io_write_data[7:0];
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               timer_d = RELOAD;
               state_d = S_START;
            end
         end
         S_START: begin
            if (timer_q == '0) begin
               timer_d = RELOAD;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_DATA: begin
            if (timer_q == '0) begin
               timer_d = RELOAD;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_STOP: begin
            if (timer_q == '0) begin
               timer_d = RELOAD;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Line level follows the state one cycle later so the output is a clean flop.
   always_comb begin
      case (state_q)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         leds_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= S_IDLE;
         timer_q  <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         if (wr_led) leds_q <= io_write_data[7:0];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         timer_q  <= timer_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

`ifdef J2_IO_COUNTER_EN
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wr_cnt;

   assign wr_cnt = io_write_enable && (sel == 2'd3);
   assign cnt_d  = wr_cnt ? '0 : cnt_q + WIDTH'(1);
   assign cnt_rd = cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign cnt_rd = '0;
`endif

   always_comb begin
      io_read_data = '0;
      case (sel)
         2'd0:    io_read_data = {{(WIDTH-8){1'b0}}, leds_q};
         2'd1:    io_read_data = '0;
         2'd2:    io_read_data = {{(WIDTH-8){1'b0}}, cnt_sat, ovf_q, busy, empty, full};
         default: io_read_data = cnt_rd;
      endcase
   end

endmodule

// File: tb/tb_j2_io_responder.sv
// Bench for j2_io_responder: randomized register/UART traffic, frame-level reference model, UART scoreboard.
// Counter checks follow J2_IO_COUNTER_EN.
module tb_j2_io_responder;
   localparam int CPB   = 4;
   localparam int DEPTH = 8;
   localparam int W     = 16;
   localparam int FRAME = 10 * CPB;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [15:0]   io_address = '0;
   logic          we = 1'b0, re = 1'b0;
   logic [W-1:0]  wdata = '0;
   logic [W-1:0]  rdata;
   logic [7:0]    leds;
   logic          uart_tx;

   j2_io_responder #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .CLOCKS_PER_BIT(CPB)) dut (
      .clock(clock), .reset(reset), .io_address(io_address),
      .io_write_enable(we), .io_read_enable(re), .io_write_data(wdata),
      .io_read_data(rdata), .leds(leds), .uart_tx(uart_tx)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Reference model: FIFO contents, last pop time; a frame occupies FRAME cycles after its pop.
   typedef struct { logic [7:0] d; int start; } exp_t;
   int         cyc = 0;
   int         last_pop = -1000;
   logic [7:0] mq[$];
   exp_t       sb[$];
   logic       m_ovf = 1'b0;
   logic [7:0] m_leds = '0;
   logic [W-1:0] m_cnt = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] m_status();
      int n;
      logic [3:0] sat;
      logic bsy;
      n   = mq.size();
      sat = (n > 15) ? 4'hF : 4'(n);
      bsy = (cyc < last_pop + FRAME);
      return {8'h00, sat, m_ovf, bsy, (n == 0), (n == DEPTH)};
   endfunction

   function automatic logic [W-1:0] m_read(input logic [1:0] a);
      case (a)
         2'd0: return {8'h00, m_leds};
         2'd1: return '0;
         2'd2: return m_status();
`ifdef J2_IO_COUNTER_EN
         default: return m_cnt;
`else
         default: return '0;
`endif
      endcase
   endfunction

   initial begin : model
      logic       pop, full, push;
      logic [7:0] b;
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            mq.delete();
            sb.delete();
            m_ovf    = 1'b0;
            m_leds   = '0;
            m_cnt    = '0;
            last_pop = cyc - FRAME;
         end else begin
            cyc++;
            push = we && (io_address[1:0] == 2'd1);
            pop  = (mq.size() > 0) && (cyc >= last_pop + FRAME);
            full = (mq.size() == DEPTH);
            if (pop) begin
               b = mq.pop_front();
               sb.push_back('{d: b, start: cyc + 1});
               last_pop = cyc;
            end
            if (push && (!full || pop)) mq.push_back(wdata[7:0]);
            if (re && io_address[1:0] == 2'd2) m_ovf = 1'b0;
            if (push && full && !pop) m_ovf = 1'b1;
            if (we && io_address[1:0] == 2'd0) m_leds = wdata[7:0];
            if (we && io_address[1:0] == 2'd3) m_cnt = '0;
            else                               m_cnt = m_cnt + 1'b1;
         end
      end
   end

   // UART monitor: decodes each frame and checks it against the scoreboard.
   initial begin : monitor
      int         st;
      logic       aborted;
      logic [9:0] bits;
      exp_t       e;
      forever begin
         @(negedge clock);
         if (!reset && uart_tx === 1'b0) begin
            st      = cyc;
            aborted = 1'b0;
            bits    = '0;
            for (int k = 1; k < 10 && !aborted; k++) begin
               repeat (CPB) begin
                  @(negedge clock);
                  if (reset) aborted = 1'b1;
               end
               bits[k] = uart_tx;
            end
            if (!aborted) begin
               repeat (CPB - 1) @(negedge clock);
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL uart_unexpected_frame: got data %h expected none", bits[8:1]);
               end else begin
                  e = sb.pop_front();
                  check("uart_frame_start", st, e.start);
                  check("uart_frame_bits", {22'd0, bits}, {22'd0, 1'b1, e.d, 1'b0});
               end
            end
         end
      end
   end

   task automatic drive(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
      @(negedge clock);
      we         = w;
      re         = r;
      io_address = {14'($urandom), a};
      wdata      = {8'($urandom), d};
      #1;
   endtask

   task automatic check_status(input logic r);
      drive(1'b0, r, 2'd2, 8'h00);
      check("status", rdata, m_status());
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb.size() != 0 || mq.size() != 0 || cyc < last_pop + FRAME + 2) && n < 3000) begin
         drive(1'b0, 1'b0, 2'd2, 8'h00);
         n++;
      end
      if (n >= 3000) begin
         tests++;
         fails++;
         $display("FAIL wait_idle_timeout: got %0d pending frames expected 0", sb.size() + mq.size());
      end
   endtask

   initial begin : watchdog
      #1500000;
      fails++;
      $display("FAIL watchdog: got no finish expected finish by time limit");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : stim
      logic [7:0] v;
      int         k;
      repeat (3) @(negedge clock);
      io_address = 16'h0002;
      #1;
      check("reset_uart_tx", uart_tx, 1);
      check("reset_leds", leds, 0);
      check("reset_status", rdata, 16'h0002);
      @(negedge clock);
      reset = 1'b0;

      drive(1'b1, 1'b0, 2'd0, 8'hA5);
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      check("led_a5", leds, 8'hA5);
      check("led_read_a5", rdata, 16'h00A5);
      for (int i = 0; i < 4; i++) begin
         v = 8'($urandom);
         drive(1'b1, 1'b0, 2'd0, v);
         drive(1'b0, 1'b0, 2'd0, 8'h00);
         check("led_rand", leds, v);
         check("led_read_rand", rdata, {8'h00, v});
      end
      drive(1'b0, 1'b0, 2'd1, 8'h00);
      check("tx_read_zero", rdata, 0);

      drive(1'b1, 1'b0, 2'd1, 8'h55);
      repeat (FRAME + 4) check_status(1'b0);
      wait_idle();

      drive(1'b1, 1'b0, 2'd1, 8'($urandom));
      repeat (3) drive(1'b0, 1'b0, 2'd2, 8'h00);
      repeat (9) drive(1'b1, 1'b0, 2'd1, 8'($urandom));
      check_status(1'b0);
      check("overflow_set", rdata[3], 1);
      check_status(1'b1);
      check_status(1'b0);
      check("overflow_cleared", rdata[3], 0);
      wait_idle();

      drive(1'b1, 1'b0, 2'd1, 8'($urandom));
      repeat (3) drive(1'b0, 1'b0, 2'd2, 8'h00);
      repeat (DEPTH) drive(1'b1, 1'b0, 2'd1, 8'($urandom));
      k = 0;
      while (cyc + 1 != last_pop + FRAME && k < 4 * FRAME) begin
         drive(1'b0, 1'b0, 2'd2, 8'h00);
         k++;
      end
      we         = 1'b1;
      io_address = 16'h0001;
      wdata      = {8'h00, 8'($urandom)};
      drive(1'b0, 1'b0, 2'd2, 8'h00);
      check("push_at_pop_status", rdata, m_status());
      check("push_at_pop_count", rdata[7:0], 8'h85);
      wait_idle();

      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 9);
         v = 8'($urandom);
         if (k <= 2)      drive(1'b1, 1'b0, 2'd1, v);
         else if (k == 3) drive(1'b1, 1'b0, 2'd0, v);
         else if (k <= 5) drive(1'b0, 1'($urandom), 2'd2, v);
         else if (k == 6) drive(1'b1, 1'b0, 2'd3, v);
         else             drive(1'b0, 1'b0, 2'($urandom), v);
         check("rand_read", rdata, m_read(io_address[1:0]));
      end
      wait_idle();

      drive(1'b1, 1'b0, 2'd0, 8'h3C);
      drive(1'b1, 1'b0, 2'd1, 8'($urandom));
      repeat (CPB + 4) drive(1'b0, 1'b0, 2'd2, 8'h00);
      @(negedge clock);
      we = 1'b0;
      io_address = 16'h0002;
      #2 reset = 1'b1;
      #1;
      check("midframe_reset_uart_tx", uart_tx, 1);
      check("midframe_reset_status", rdata, 16'h0002);
      check("midframe_reset_leds", leds, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (6) drive(1'b0, 1'b0, 2'd2, 8'h00);
      drive(1'b1, 1'b0, 2'd1, 8'hC3);
      wait_idle();

`ifdef J2_IO_COUNTER_EN
      drive(1'b1, 1'b0, 2'd3, 8'h00);
      repeat (10) drive(1'b0, 1'b0, 2'd3, 8'h00);
      drive(1'b0, 1'b1, 2'd3, 8'h00);
      check("counter_10", rdata, 16'd10);
      drive(1'b1, 1'b0, 2'd3, 8'h00);
      repeat (65535) drive(1'b0, 1'b0, 2'd3, 8'h00);
      drive(1'b0, 1'b0, 2'd3, 8'h00);
      check("counter_max", rdata, 16'hFFFF);
      drive(1'b0, 1'b0, 2'd3, 8'h00);
      check("counter_wrap", rdata, 16'h0000);
`else
      drive(1'b0, 1'b0, 2'd3, 8'h00);
      check("counter_absent", rdata, 0);
      drive(1'b1, 1'b0, 2'd3, 8'hFF);
      repeat (3) drive(1'b0, 1'b0, 2'd3, 8'h00);
      check("counter_absent_after_write", rdata, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/j2_io_responder.md
Name: j2_io_responder

Overview:
- IO-side responder for the j2 core: decodes the core's IO accesses and returns io read data; owns the peripheral registers.
- Registers: LED output register, UART transmit FIFO with 8N1 serializer, status register, free-running cycle counter.
- Connects to core memory_address / data_out / io_write_enable and drives the core's io_data_in.

Parameters:
- WIDTH, 16, data word width; matches the core's `WIDTH.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, at least 2.
- CLOCKS_PER_BIT, 434, clock cycles per serial bit; at least 2.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- io_address  input  16  from core memory_address; register select = io_address[1:0]
- io_write_enable  input  1  one-cycle write strobe from core
- io_read_enable  input  1  one-cycle read strobe; qualifies read side effects only
- io_write_data  input  WIDTH  from core data_out
- io_read_data  output  WIDTH  to core io_data_in; combinational mux of registers by io_address[1:0]
- leds  output  8  LED register contents
- uart_tx  output  1  registered serial output, idle high

Behaviour:
- Reset (async, any time, including mid-frame): leds=0, uart_tx=1, FIFO empty, count=0, overflow=0, cycle counter=0, FSM IDLE. A partial frame is abandoned with no glitch low.
- Register map (io_address[1:0]):
  - 0 LED: write loads io_write_data[7:0]; read returns {0, leds}.
  - 1 TX: write pushes io_write_data[7:0]; read returns 0.
  - 2 STATUS, read-only: bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 overflow (sticky), bits[7:4] FIFO count saturated to 15, upper bits 0. A read with io_read_enable clears overflow on the next edge.
  - 3 COUNTER: read returns count; any write clears it to 0.
- Writes take effect on the edge of the strobe cycle. Reads have zero latency.
- Push when full and no pop in the same cycle: data dropped, overflow set.
- Push and pop in the same cycle when full: both accepted, count unchanged, overflow not set.
- Push when empty: entry stored; it cannot be popped in that cycle.
- Pointers wrap modulo FIFO_DEPTH.
- Counter: increments every cycle, wraps 2^WIDTH-1 -> 0. A write in the same cycle wins, giving 0 on the next edge.
- TX FSM states: IDLE, START, DATA, STOP. Bit timer reloads to CLOCKS_PER_BIT-1 on each bit boundary.
  - IDLE: if FIFO not empty, pop into shift register -> START.
  - START: uart_tx=0 for CLOCKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, CLOCKS_PER_BIT cycles each -> STOP.
  - STOP: uart_tx=1 for CLOCKS_PER_BIT cycles. At the end, if FIFO not empty, pop -> START (back-to-back); otherwise -> IDLE.
- Timing: TX write in cycle N gives count=1 after edge N; pop at edge N+1; uart_tx low from edge N+2. Each frame is exactly 10*CLOCKS_PER_BIT cycles.

Optional Feature:
- J2_IO_COUNTER_EN defined: cycle counter present as described.
- Not defined: no counter flops; address 3 reads 0 and writes to it are ignored.
- All other behaviour is identical either way.

Test Plan:
- Reset mid-frame (CLOCKS_PER_BIT=4, reset asserted during DATA) -> uart_tx=1 immediately; STATUS reads 0x0002; leds=0.
- Write 0x00A5 to addr 0, then read addr 0 -> leds=0xA5, io_read_data=0x00A5 in the same cycle as the address.
- Write 0x55 to addr 1 at cycle N (CLOCKS_PER_BIT=4) -> uart_tx low from N+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0, then high 4 cycles; busy=1 throughout the 40-cycle frame.
- Push 9 bytes back-to-back with FIFO_DEPTH=8 (first pop not yet occurred) -> 9th dropped, STATUS bit3=1; STATUS read with io_read_enable clears bit3; 8 frames sent with no idle gap.
- Push at the exact cycle the FSM pops from a full FIFO -> count stays 8, overflow stays 0, all bytes transmitted in order.
- With J2_IO_COUNTER_EN: write addr 3, read after 10 cycles -> 10; preload to 0xFFFF -> wraps to 0. Without the macro: read addr 3 -> 0.
